cdb_rr_scheduler: RTL
=====================

# cdb_rr_scheduler

Round-robin scheduler that shares the NUM_CDB common data buses among all ALU/CMP and MULT functional units. It replaces fixed-priority CDB selection with rotating fairness, a starvation override, and a registered broadcast stage. It sits between the FU output ports and the CDB consumers: ROB, reservation stations, physical register file and branch recovery.

## Interface
Parameters:
- NUM_ALU_CMP_UNITS, default 2: number of ALU/CMP requesters.
- NUM_MULT_UNITS, default 1: number of MULT requesters.
- NUM_CDB, default 2: number of broadcast buses, 1..NUM_ALU_CMP_UNITS+NUM_MULT_UNITS.
- STARVE_LIMIT, default 4: number of consecutive lost cycles after which a requester is forced onto cdb[0]. Must be ≥1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  branch-mispredict flush; kills all grants and in-flight broadcasts.
- alu_cmp_done  in  NUM_ALU_CMP_UNITS  per-unit result-ready request.
- alu_cmp_output_data  in  fu_cdb_data_t[NUM_ALU_CMP_UNITS]  per-unit result payload.
- mult_done  in  NUM_MULT_UNITS  per-unit result-ready request.
- mult_output_data  in  fu_cdb_data_t[NUM_MULT_UNITS]  per-unit result payload.
- alu_cmp_ack  out  NUM_ALU_CMP_UNITS  same-cycle grant; the FU drops done on the next edge.
- mult_ack  out  NUM_MULT_UNITS  same-cycle grant.
- cdb  out  cdb_t[NUM_CDB]  registered broadcast buses.

## Operation
- Flattened requester index r, N = NUM_ALU_CMP_UNITS+NUM_MULT_UNITS:
  - ALU/CMP unit i maps to r = i.
  - MULT unit j maps to r = NUM_ALU_CMP_UNITS+j.
- State:
  - rr_ptr, width $clog2(N) (min 1), value 0..N-1.
  - One wait counter per requester, width $clog2(STARVE_LIMIT+1), saturating at STARVE_LIMIT.
  - NUM_CDB registered cdb_t entries.
- Starvation override:
  - A requester is starved when done=1 and its counter = STARVE_LIMIT.
  - The lowest-index starved requester is granted cdb[0] first.
- Rotation fill:
  - Scan r = rr_ptr, rr_ptr+1, … mod N, skipping the starved winner.
  - Assign remaining requesting units to the next free cdb index in scan order, until NUM_CDB grants are made or requesters are exhausted.
- ack is asserted for exactly the granted units and is combinational from done, rr_ptr and the counters.
- rr_ptr update, only when at least one rotation-fill grant occurs: rr_ptr ← (last rotation-granted r + 1) mod N. A starved-only grant leaves rr_ptr unchanged.
- Wait counters:
  - Granted unit: 0.
  - Requesting and not granted: +1, saturating.
  - Not requesting: 0.
- Payload capture into cdb[k] on the edge:
  - valid=1; pd_s, rob_num, pd_v and rvfi_data copied from the granted unit.
  - ALU/CMP source: br_en = data.br_en, branch_pc = data.br_target.
  - MULT source: br_en=0, branch_pc don't-care.
- Unused cdb[k]: valid=0, br_en=0, other fields don't-care.
- Flush:
  - All acks forced to 0 that cycle.
  - All cdb valid and br_en are 0 on the next edge.
  - Counters are cleared; rr_ptr holds.
- Reset (rst=0), asynchronous: rr_ptr=0, counters=0, all cdb valid=0 and br_en=0. acks are 0 while rst=0.

## Timing
- done at cycle t with grant → ack high in cycle t; cdb[k].valid=1 with that payload in cycle t+1, for exactly one cycle unless re-granted.
- Throughput: up to NUM_CDB results per cycle, back-to-back with no bubbles.
- A requester that is not granted holds done and payload stable; the scheduler does not latch ungranted data.
- Worst-case wait: STARVE_LIMIT+1 cycles from done to ack.
- Flush and done in the same cycle: flush wins; no ack, no broadcast.
- Deassertion of rst is taken synchronously to clk by the surrounding reset synchronizer; the first grant is possible on the first edge after release.

## Test plan
- Test plan config: N=3 (ALU0, ALU1, MULT0), NUM_CDB=1, STARVE_LIMIT=4.
- Reset mid-operation: drive rst=0 while cdb[0].valid=1 → cdb[0].valid=0 and all acks 0 immediately (asynchronous); after release, rr_ptr=0.
- Rotation: hold all three done=1 for 6 cycles → acks in order ALU0, ALU1, MULT0, ALU0, ALU1, MULT0; each cdb[0] appears one cycle after its ack with the matching rob_num.
- Starvation: ALU1 done=1 continuously while ALU0 and MULT0 also request, and rr_ptr is forced past ALU1 repeatedly via done toggling → ALU1 acked no later than its 5th cycle of waiting, on cdb[0].
- Flush: flush=1 in the same cycle as MULT0 done=1 → mult_ack=0; next cycle cdb[0].valid=0; counters read 0; MULT0 is acked the following cycle.
- Multi-CDB (NUM_CDB=2): ALU0 done with br_en=1, br_target=0x0000_1040, together with MULT0 done → both acked the same cycle; next cycle one bus carries br_en=1, branch_pc=0x0000_1040 and the other carries br_en=0.

Source files
------------

// File: rtl/cdb_rr_scheduler.sv
`timescale 1ns/1ps
// Shared types for results leaving the functional units and for the broadcast buses.
// fu_cdb_data_t: one FU result payload. cdb_t: one registered broadcast-bus entry.
package cdb_pkg;
  typedef struct packed {
    logic [5:0]  pd_s;
    logic [4:0]  rob_num;
    logic [31:0] pd_v;
    logic        br_en;
    logic [31:0] br_target;
    logic [31:0] rvfi_data;
  } fu_cdb_data_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  pd_s;
    logic [4:0]  rob_num;
    logic [31:0] pd_v;
    logic        br_en;
    logic [31:0] branch_pc;
    logic [31:0] rvfi_data;
  } cdb_t;
endpackage

// Purpose: round-robin arbiter sharing NUM_CDB broadcast buses among ALU/CMP and MULT units, with starvation override.
// Latency: ack is combinational in the request cycle; the granted payload appears on cdb one edge later.
// Backpressure: an ungranted unit holds done/payload until acked; flush suppresses all acks and broadcasts.
// Ports: clk/rst (async active-low), flush, {alu_cmp,mult}_done + _output_data in, {alu_cmp,mult}_ack out,
//        cdb[NUM_CDB] registered buses out.
module cdb_rr_scheduler
  import cdb_pkg::*;
#(
  parameter int NUM_ALU_CMP_UNITS = 2,
  parameter int NUM_MULT_UNITS    = 1,
  parameter int NUM_CDB           = 2,
  parameter int STARVE_LIMIT      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [NUM_ALU_CMP_UNITS-1:0]          alu_cmp_done,
  input  fu_cdb_data_t [NUM_ALU_CMP_UNITS-1:0]  alu_cmp_output_data,
  input  logic [NUM_MULT_UNITS-1:0]             mult_done,
  input  fu_cdb_data_t [NUM_MULT_UNITS-1:0]     mult_output_data,
  output logic [NUM_ALU_CMP_UNITS-1:0]          alu_cmp_ack,
  output logic [NUM_MULT_UNITS-1:0]             mult_ack,
  output cdb_t [NUM_CDB-1:0]                    cdb
);
  localparam int N  = NUM_ALU_CMP_UNITS + NUM_MULT_UNITS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  // Flattened requester vector: ALU/CMP units low, MULT units above them.
  logic [N-1:0]    req;
  logic [PW-1:0]   rr_ptr;
  logic [CW-1:0]   wait_cnt [N];

  logic [N-1:0]    grant;
  logic            bus_vld  [NUM_CDB];
  logic [PW-1:0]   bus_src  [NUM_CDB];
  cdb_t            bus_nxt  [NUM_CDB];
  logic            rot_any;
  logic [PW-1:0]   rot_last;
  logic            starve_hit;
  logic [PW-1:0]   starve_r;
  logic [PW:0]     scan_w;
  logic [PW-1:0]   scan_r;
  int              nxt;
  logic            ack_en;

  assign req    = {mult_done, alu_cmp_done};
  assign ack_en = rst & ~flush;

  // Grant selection: the lowest-index starved requester owns cdb[0], then the
  // remaining buses are filled in rotating order starting at rr_ptr.
  always_comb begin
    grant      = '0;
    rot_any    = 1'b0;
    rot_last   = '0;
    starve_hit = 1'b0;
    starve_r   = '0;
    scan_w     = '0;
    scan_r     = '0;
    nxt        = 0;
    for (int k = 0; k < NUM_CDB; k++) begin
      bus_vld[k] = 1'b0;
      bus_src[k] = '0;
    end

    // Descending scan so the last hit is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (wait_cnt[i] == CW'(STARVE_LIMIT))) begin
        starve_hit = 1'b1;
        starve_r   = PW'(i);
      end
    end

    if (starve_hit) begin
      grant[starve_r] = 1'b1;
      bus_vld[0]      = 1'b1;
      bus_src[0]      = starve_r;
      nxt             = 1;
    end

    for (int o = 0; o < N; o++) begin
      scan_w = {1'b0, rr_ptr} + (PW+1)'(o);
      if (scan_w >= (PW+1)'(N)) begin
        scan_w = scan_w - (PW+1)'(N);
      end
      scan_r = scan_w[PW-1:0];
      if (req[scan_r] && !grant[scan_r] && (nxt < NUM_CDB)) begin
        grant[scan_r] = 1'b1;
        for (int k = 0; k < NUM_CDB; k++) begin
          if (k == nxt) begin
            bus_vld[k] = 1'b1;
            bus_src[k] = scan_r;
          end
        end
        nxt      = nxt + 1;
        rot_any  = 1'b1;
        rot_last = scan_r;
      end
    end
  end

  assign alu_cmp_ack = grant[NUM_ALU_CMP_UNITS-1:0] & {NUM_ALU_CMP_UNITS{ack_en}};
  assign mult_ack    = grant[N-1:NUM_ALU_CMP_UNITS] & {NUM_MULT_UNITS{ack_en}};

  // Payload mux per bus. MULT results never carry a branch outcome.
  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      bus_nxt[k] = '0;
      for (int i = 0; i < NUM_ALU_CMP_UNITS; i++) begin
        if (bus_src[k] == PW'(i)) begin
          bus_nxt[k].pd_s      = alu_cmp_output_data[i].pd_s;
          bus_nxt[k].rob_num   = alu_cmp_output_data[i].rob_num;
          bus_nxt[k].pd_v      = alu_cmp_output_data[i].pd_v;
          bus_nxt[k].rvfi_data = alu_cmp_output_data[i].rvfi_data;
          bus_nxt[k].br_en     = alu_cmp_output_data[i].br_en;
          bus_nxt[k].branch_pc = alu_cmp_output_data[i].br_target;
        end
      end
      for (int j = 0; j < NUM_MULT_UNITS; j++) begin
        if (bus_src[k] == PW'(NUM_ALU_CMP_UNITS + j)) begin
          bus_nxt[k].pd_s      = mult_output_data[j].pd_s;
          bus_nxt[k].rob_num   = mult_output_data[j].rob_num;
          bus_nxt[k].pd_v      = mult_output_data[j].pd_v;
          bus_nxt[k].rvfi_data = mult_output_data[j].rvfi_data;
          bus_nxt[k].br_en     = 1'b0;
          bus_nxt[k].branch_pc = '0;
        end
      end
      bus_nxt[k].valid = bus_vld[k];
      bus_nxt[k].br_en = bus_nxt[k].br_en & bus_vld[k];
    end
  end

  // Broadcast registers: flush only kills valid/br_en, the rest is don't-care.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb[k].valid <= 1'b0;
        cdb[k].br_en <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb[k] <= bus_nxt[k];
      end
    end
  end

  // Pointer advances past the last rotation winner; a starved-only grant
  // leaves it alone so the rotation order is not disturbed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (!flush && rot_any) begin
      rr_ptr <= (rot_last == PW'(N - 1)) ? '0 : rot_last + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        wait_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        if (flush || grant[r] || !req[r]) begin
          wait_cnt[r] <= '0;
        end else if (wait_cnt[r] != CW'(STARVE_LIMIT)) begin
          wait_cnt[r] <= wait_cnt[r] + 1'b1;
        end
      end
    end
  end

endmodule
